// File: rtl/snake_step_scheduler_if.sv
// Handshake/control bundle between the snake step scheduler and its surroundings.
// The scheduler drives the o_* signals and samples the i_* signals.
interface snake_step_scheduler_if;
  logic [2:0] i_user_dir;
  logic       i_start;
  logic       i_pause;
  logic       i_core_done;
  logic [3:0] i_core_size;
  logic       o_core_reset;
  logic       o_step;
  logic [1:0] o_dir;
  logic [1:0] o_rand_dir;
  logic [2:0] o_state;

  modport slave (
    input  i_user_dir, i_start, i_pause, i_core_done, i_core_size,
    output o_core_reset, o_step, o_dir, o_rand_dir, o_state
  );

  modport master (
    output i_user_dir, i_start, i_pause, i_core_done, i_core_size,
    input  o_core_reset, o_step, o_dir, o_rand_dir, o_state
  );
endinterface

// File: rtl/snake_step_scheduler.sv
// Game-tick sequencer for the snake core: tick divider, 2-deep direction queue,
// start/pause/over FSM and a free-running LFSR for random directions.
module snake_step_scheduler #(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned SPEED_STEP  = 1_000_000,
  parameter int unsigned MIN_TICK    = 5_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  snake_step_scheduler_if.slave bus
);

  localparam int unsigned PW = CNT_W + 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StInit  = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    period_q, period_d;
  logic             step_q, step_d;
  logic             core_reset_q, core_reset_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       q0_q, q0_d, q1_q, q1_d;
  logic [1:0]       qcnt_q, qcnt_d;
  logic [2:0]       prev_dir_q;
  logic             pause_prev_q;
  logic [7:0]       lfsr_q, lfsr_d;

  logic [PW-1:0] tick_w, min_w, sub_w, period_w;
  logic          pause_rise, tick_last;
  logic [1:0]    code, tail, ref_dir;
  logic          press, accept;

  // Saturating period: compare against the headroom so the subtraction never wraps.
  assign tick_w   = PW'(TICK_CYCLES);
  assign min_w    = PW'(MIN_TICK);
  assign sub_w    = PW'(SPEED_STEP) * PW'(bus.i_core_size);
  assign period_w = (sub_w >= (tick_w - min_w)) ? min_w : (tick_w - sub_w);

  assign pause_rise = bus.i_pause & ~pause_prev_q;
  assign tick_last  = ({4'b0000, cnt_q} == (period_q - PW'(1)));

  assign code    = bus.i_user_dir[1:0];
  assign press   = ~bus.i_user_dir[2] & (prev_dir_q[2] | (code != prev_dir_q[1:0]));
  assign tail    = (qcnt_q == 2'd2) ? q1_q : q0_q;
  assign ref_dir = (qcnt_q == 2'd0) ? dir_q : tail;
  // Codes pair as up/down and left/right, so the reverse differs only in bit 0.
  assign accept  = press && (qcnt_q != 2'd2) && (code != ref_dir) &&
                   (code != (ref_dir ^ 2'b01));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.i_start) state_d = StInit;
      StInit:  state_d = StRun;
      StRun: begin
        if (bus.i_core_done) state_d = StOver;
        else if (pause_rise) state_d = StPause;
      end
      StPause: if (pause_rise) state_d = StRun;
      StOver:  if (bus.i_start) state_d = StInit;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    period_d     = period_q;
    step_d       = 1'b0;
    core_reset_d = (state_d == StInit);
    case (state_q)
      StRun: begin
        if (tick_last) begin
          cnt_d    = '0;
          step_d   = 1'b1;
          period_d = period_w;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StInit: begin
        cnt_d    = '0;
        period_d = period_w;
      end
      StPause: cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    dir_d  = dir_q;
    q0_d   = q0_q;
    q1_d   = q1_q;
    qcnt_d = qcnt_q;
    if (state_q == StInit) begin
      dir_d  = 2'd3;
      qcnt_d = 2'd0;
    end else begin
      if (step_d && (qcnt_q != 2'd0)) begin
        dir_d  = q0_q;
        q0_d   = q1_q;
        qcnt_d = qcnt_q - 2'd1;
      end
      if (accept) begin
        if (qcnt_d == 2'd0) q0_d = code;
        else                q1_d = code;
        qcnt_d = qcnt_d + 2'd1;
      end
    end
  end

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (lfsr_q == 8'h00) lfsr_d = 8'hA5;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      period_q     <= PW'(TICK_CYCLES);
      step_q       <= 1'b0;
      core_reset_q <= 1'b0;
      dir_q        <= 2'd3;
      q0_q         <= 2'd0;
      q1_q         <= 2'd0;
      qcnt_q       <= 2'd0;
      prev_dir_q   <= 3'b100;
      pause_prev_q <= 1'b0;
      lfsr_q       <= 8'hA5;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      step_q       <= step_d;
      core_reset_q <= core_reset_d;
      dir_q        <= dir_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      qcnt_q       <= qcnt_d;
      prev_dir_q   <= bus.i_user_dir;
      pause_prev_q <= bus.i_pause;
      lfsr_q       <= lfsr_d;
    end
  end

  assign bus.o_step       = step_q;
  assign bus.o_core_reset = core_reset_q;
  assign bus.o_dir        = dir_q;
  assign bus.o_rand_dir   = lfsr_q[1:0];
  assign bus.o_state      = state_q;

endmodule
